// File: rtl/sample_discriminator.sv
// sample_discriminator
//   Per-channel threshold discriminator with hysteresis. A channel opens a
//   segment when any sample of a valid word rises strictly above its high
//   threshold. It closes the segment when every sample of a valid word is
//   strictly below its low threshold. Only words inside a segment are forwarded.
//   The first word of a segment carries the input-cycle timestamp. The last
//   word of a segment is flagged.
//
// Ports
//   clk              : single clock
//   reset            : synchronous, active-high
//   adc_data         : CHANNELS words of PARALLEL_SAMPLES signed samples
//   adc_valid        : per-channel word valid
//   cfg_thresh_high  : per-channel signed high threshold
//   cfg_thresh_low   : per-channel signed low threshold
//   cfg_valid        : threshold load request
//   cfg_ready        : threshold load accept (high whenever reset is low)
//   out_data         : forwarded words
//   out_valid        : per-channel forwarded-word valid
//   out_last         : final word of a segment (qualified by out_valid)
//   out_ts           : per-channel segment start timestamp
//   out_ts_valid     : one-cycle pulse with the first word of a segment
//
// Latency is 2 cycles. Stage 1 registers the word, its valid, the timestamp
// and the threshold comparisons. Stage 2 runs the per-channel FSM and
// registers the outputs.
module sample_discriminator #(
  parameter int CHANNELS         = 8,
  parameter int PARALLEL_SAMPLES = 8,
  parameter int SAMPLE_WIDTH     = 16,
  parameter int TIMESTAMP_WIDTH  = 48
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic [CHANNELS*PARALLEL_SAMPLES*SAMPLE_WIDTH-1:0] adc_data,
  input  logic [CHANNELS-1:0]                              adc_valid,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0]                 cfg_thresh_high,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0]                 cfg_thresh_low,
  input  logic                                             cfg_valid,
  output logic                                             cfg_ready,
  output logic [CHANNELS*PARALLEL_SAMPLES*SAMPLE_WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]                              out_valid,
  output logic [CHANNELS-1:0]                              out_last,
  output logic [CHANNELS*TIMESTAMP_WIDTH-1:0]              out_ts,
  output logic [CHANNELS-1:0]                              out_ts_valid
);

  localparam int WORD_W = PARALLEL_SAMPLES * SAMPLE_WIDTH;
  localparam int DATA_W = CHANNELS * WORD_W;

  // Reset thresholds sit at the extremes of the sample range, so no word can
  // trigger until real thresholds are loaded.
  localparam logic [SAMPLE_WIDTH-1:0] S_MAX = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic [SAMPLE_WIDTH-1:0] S_MIN = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

  // True when any sample of the word is strictly above thr (signed)
  function automatic logic any_above(input logic [WORD_W-1:0] word,
                                     input logic signed [SAMPLE_WIDTH-1:0] thr);
    logic hit;
    hit = 1'b0;
    for (int s = 0; s < PARALLEL_SAMPLES; s++) begin
      hit |= ($signed(word[s*SAMPLE_WIDTH +: SAMPLE_WIDTH]) > thr);
    end
    return hit;
  endfunction

  // True when every sample of the word is strictly below thr (signed)
  function automatic logic all_below(input logic [WORD_W-1:0] word,
                                     input logic signed [SAMPLE_WIDTH-1:0] thr);
    logic ok;
    ok = 1'b1;
    for (int s = 0; s < PARALLEL_SAMPLES; s++) begin
      ok &= ($signed(word[s*SAMPLE_WIDTH +: SAMPLE_WIDTH]) < thr);
    end
    return ok;
  endfunction

  logic [CHANNELS*SAMPLE_WIDTH-1:0] thr_high_q, thr_high_d;
  logic [CHANNELS*SAMPLE_WIDTH-1:0] thr_low_q, thr_low_d;
  logic [TIMESTAMP_WIDTH-1:0]       ts_q, ts_d;
  logic [CHANNELS-1:0]              above_d, below_d;

  logic [DATA_W-1:0]          s1_data_q;
  logic [CHANNELS-1:0]        s1_valid_q, s1_above_q, s1_below_q;
  logic [TIMESTAMP_WIDTH-1:0] s1_ts_q;

  state_e state_q [CHANNELS];
  state_e state_d [CHANNELS];

  logic [DATA_W-1:0]                   out_data_q, out_data_d;
  logic [CHANNELS-1:0]                 out_valid_q, out_valid_d;
  logic [CHANNELS-1:0]                 out_last_q, out_last_d;
  logic [CHANNELS*TIMESTAMP_WIDTH-1:0] out_ts_q, out_ts_d;
  logic [CHANNELS-1:0]                 out_ts_valid_q, out_ts_valid_d;

  assign cfg_ready    = ~reset;
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign out_ts       = out_ts_q;
  assign out_ts_valid = out_ts_valid_q;

  // Threshold load, timestamp increment and input-side comparisons
  always_comb begin
    thr_high_d = thr_high_q;
    thr_low_d  = thr_low_q;
    if (cfg_valid && cfg_ready) begin
      thr_high_d = cfg_thresh_high;
      thr_low_d  = cfg_thresh_low;
    end else begin
      thr_high_d = thr_high_q;
      thr_low_d  = thr_low_q;
    end
    ts_d = ts_q + TIMESTAMP_WIDTH'(1);
    for (int c = 0; c < CHANNELS; c++) begin
      above_d[c] = any_above(adc_data[c*WORD_W +: WORD_W],
                             thr_high_q[c*SAMPLE_WIDTH +: SAMPLE_WIDTH]);
      below_d[c] = all_below(adc_data[c*WORD_W +: WORD_W],
                             thr_low_q[c*SAMPLE_WIDTH +: SAMPLE_WIDTH]);
    end
  end

  // Threshold registers, timestamp counter and stage-1 pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      thr_high_q <= {CHANNELS{S_MAX}};
      thr_low_q  <= {CHANNELS{S_MIN}};
      ts_q       <= '0;
      s1_data_q  <= '0;
      s1_valid_q <= '0;
      s1_above_q <= '0;
      s1_below_q <= '0;
      s1_ts_q    <= '0;
    end else begin
      thr_high_q <= thr_high_d;
      thr_low_q  <= thr_low_d;
      ts_q       <= ts_d;
      s1_data_q  <= adc_data;
      s1_valid_q <= adc_valid;
      s1_above_q <= above_d;
      s1_below_q <= below_d;
      s1_ts_q    <= ts_q;
    end
  end

  // Per-channel segment FSM and stage-2 output selection
  always_comb begin
    out_valid_d    = '0;
    out_last_d     = '0;
    out_ts_valid_d = '0;
    out_data_d     = out_data_q;
    out_ts_d       = out_ts_q;
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c] = state_q[c];
      if (s1_valid_q[c]) begin
        case (state_q[c])
          IDLE: begin
            if (s1_above_q[c]) begin
              // A trigger word may also satisfy the exit test (low > high):
              // it then opens and closes the segment in one word.
              out_valid_d[c]    = 1'b1;
              out_ts_valid_d[c] = 1'b1;
              out_last_d[c]     = s1_below_q[c];
              out_data_d[c*WORD_W +: WORD_W] = s1_data_q[c*WORD_W +: WORD_W];
              out_ts_d[c*TIMESTAMP_WIDTH +: TIMESTAMP_WIDTH] = s1_ts_q;
              state_d[c] = s1_below_q[c] ? IDLE : ACTIVE;
            end else begin
              state_d[c] = IDLE;
            end
          end
          ACTIVE: begin
            out_valid_d[c] = 1'b1;
            out_last_d[c]  = s1_below_q[c];
            out_data_d[c*WORD_W +: WORD_W] = s1_data_q[c*WORD_W +: WORD_W];
            state_d[c] = s1_below_q[c] ? IDLE : ACTIVE;
          end
          default: begin
            state_d[c] = IDLE;
          end
        endcase
      end else begin
        state_d[c] = state_q[c];
      end
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= IDLE;
      end
      out_data_q     <= '0;
      out_valid_q    <= '0;
      out_last_q     <= '0;
      out_ts_q       <= '0;
      out_ts_valid_q <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= state_d[c];
      end
      out_data_q     <= out_data_d;
      out_valid_q    <= out_valid_d;
      out_last_q     <= out_last_d;
      out_ts_q       <= out_ts_d;
      out_ts_valid_q <= out_ts_valid_d;
    end
  end

endmodule

// File: tb/tb_sample_discriminator.sv
// Bench for sample_discriminator. Two instances share all inputs: one with a
// 48-bit timestamp and one with a 4-bit timestamp to exercise wrap-around.
// A segment model runs on each input word and predicts the outputs two cycles
// later. A compare process checks every cycle. Literal checks pin the model.
`timescale 1ns/1ps
module tb_sample_discriminator;
  localparam int CH = 8, PS = 8, SW = 16, TW = 48, TWW = 4;
  localparam int WORD_W = PS * SW, DATA_W = CH * WORD_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] adc_data = '0;
  logic [CH-1:0]     adc_valid = '0;
  logic [CH*SW-1:0]  cfg_thresh_high = '0, cfg_thresh_low = '0;
  logic              cfg_valid = 1'b0;

  logic              cfg_ready, cfg_ready_w;
  logic [DATA_W-1:0] out_data, out_data_w;
  logic [CH-1:0]     out_valid, out_valid_w, out_last, out_last_w;
  logic [CH-1:0]     out_ts_valid, out_ts_valid_w;
  logic [CH*TW-1:0]  out_ts;
  logic [CH*TWW-1:0] out_ts_w;

  always #5 clk = ~clk;

  sample_discriminator #(.CHANNELS(CH), .PARALLEL_SAMPLES(PS), .SAMPLE_WIDTH(SW),
                         .TIMESTAMP_WIDTH(TW)) u_dut (
    .clk(clk), .reset(reset), .adc_data(adc_data), .adc_valid(adc_valid),
    .cfg_thresh_high(cfg_thresh_high), .cfg_thresh_low(cfg_thresh_low),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .out_data(out_data),
    .out_valid(out_valid), .out_last(out_last), .out_ts(out_ts),
    .out_ts_valid(out_ts_valid));

  sample_discriminator #(.CHANNELS(CH), .PARALLEL_SAMPLES(PS), .SAMPLE_WIDTH(SW),
                         .TIMESTAMP_WIDTH(TWW)) u_dut_w (
    .clk(clk), .reset(reset), .adc_data(adc_data), .adc_valid(adc_valid),
    .cfg_thresh_high(cfg_thresh_high), .cfg_thresh_low(cfg_thresh_low),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_w), .out_data(out_data_w),
    .out_valid(out_valid_w), .out_last(out_last_w), .out_ts(out_ts_w),
    .out_ts_valid(out_ts_valid_w));

  int vectors = 0, miscompares = 0, cyc = 0;
  bit chk_en = 1'b0;

  // Model state: timestamp, thresholds, in-segment flag, seen-a-valid flag
  longint ts_m;
  int     hi_m [CH];
  int     lo_m [CH];
  bit     seg_m [CH];
  bit     seen_m [CH];
  // Two-entry delay line of expected outputs; [1] is due this cycle
  bit [CH-1:0]       ev [2];
  bit [CH-1:0]       el [2];
  bit [CH-1:0]       et [2];
  logic [DATA_W-1:0] ed [2];
  longint            ets [2][CH];

  // Observed-output tallies for the literal checks
  int     n_fwd [CH];
  int     n_last [CH];
  int     n_tsv [CH];
  longint cap_ts [CH];
  int     cap_tsw [CH];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin : cmp
    logic signed [SW-1:0] sv;
    int smp;
    bit any_hi, all_lo;
    cyc++;
    if (chk_en) begin
      check("cfg_ready", cfg_ready, !reset);
      check("cfg_ready_w", cfg_ready_w, !reset);
      check("out_valid", out_valid, ev[1]);
      check("out_valid_w", out_valid_w, ev[1]);
      check("out_last", out_last & out_valid, el[1]);
      check("out_last_w", out_last_w & out_valid_w, el[1]);
      check("out_ts_valid", out_ts_valid, et[1]);
      check("out_ts_valid_w", out_ts_valid_w, et[1]);
      for (int c = 0; c < CH; c++) begin
        if (ev[1][c]) begin
          check($sformatf("out_data ch%0d", c), out_data[c*WORD_W +: WORD_W], ed[1][c*WORD_W +: WORD_W]);
          check($sformatf("out_data_w ch%0d", c), out_data_w[c*WORD_W +: WORD_W], ed[1][c*WORD_W +: WORD_W]);
        end else if (!seen_m[c]) begin
          check($sformatf("out_data zero ch%0d", c), out_data[c*WORD_W +: WORD_W], 128'd0);
          check($sformatf("out_ts zero ch%0d", c), out_ts[c*TW +: TW], 128'd0);
        end
        if (et[1][c]) begin
          check($sformatf("out_ts ch%0d", c), out_ts[c*TW +: TW], ets[1][c]);
          check($sformatf("out_ts_w ch%0d", c), out_ts_w[c*TWW +: TWW], ets[1][c] & 64'hF);
        end
      end
    end
    for (int c = 0; c < CH; c++) begin
      if (out_valid[c] === 1'b1) n_fwd[c]++;
      if (out_valid[c] === 1'b1 && out_last[c] === 1'b1) n_last[c]++;
      if (out_ts_valid[c] === 1'b1) begin
        n_tsv[c]++;
        cap_ts[c]  = longint'(out_ts[c*TW +: TW]);
        cap_tsw[c] = int'(out_ts_w[c*TWW +: TWW]);
      end
      if (ev[1][c]) seen_m[c] = 1'b1;
    end
    // Advance the delay line and evaluate this cycle's input words
    ev[1] = ev[0]; el[1] = el[0]; et[1] = et[0]; ed[1] = ed[0];
    for (int c = 0; c < CH; c++) ets[1][c] = ets[0][c];
    ev[0] = '0; el[0] = '0; et[0] = '0; ed[0] = adc_data;
    for (int c = 0; c < CH; c++) ets[0][c] = ts_m;
    if (reset) begin
      ev[1] = '0; el[1] = '0; et[1] = '0;
      ts_m = 0;
      for (int c = 0; c < CH; c++) begin
        hi_m[c] = 32767; lo_m[c] = -32768; seg_m[c] = 1'b0; seen_m[c] = 1'b0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (adc_valid[c]) begin
          any_hi = 1'b0; all_lo = 1'b1;
          for (int s = 0; s < PS; s++) begin
            sv = adc_data[(c*PS+s)*SW +: SW];
            smp = sv;
            if (smp > hi_m[c]) any_hi = 1'b1;
            if (!(smp < lo_m[c])) all_lo = 1'b0;
          end
          if (seg_m[c] || any_hi) begin
            ev[0][c] = 1'b1;
            el[0][c] = all_lo;
            et[0][c] = !seg_m[c];
            seg_m[c] = !all_lo;
          end
        end
      end
      if (cfg_valid) begin
        for (int c = 0; c < CH; c++) begin
          sv = cfg_thresh_high[c*SW +: SW]; hi_m[c] = sv;
          sv = cfg_thresh_low[c*SW +: SW];  lo_m[c] = sv;
        end
      end
      ts_m++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Leaves the bench in the first post-reset cycle (ts = 0)
  task automatic do_reset();
    reset = 1'b1; adc_valid = '0; cfg_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic cfg_all(input int hi, input int lo);
    for (int c = 0; c < CH; c++) begin
      cfg_thresh_high[c*SW +: SW] = SW'(hi);
      cfg_thresh_low[c*SW +: SW]  = SW'(lo);
    end
  endtask

  task automatic word(input int c, input int v);
    for (int s = 0; s < PS; s++) adc_data[(c*PS+s)*SW +: SW] = SW'(v);
  endtask

  task automatic rand_word(input int c, input int lo, input int hi);
    for (int s = 0; s < PS; s++)
      adc_data[(c*PS+s)*SW +: SW] = SW'(lo + int'($urandom_range(hi - lo)));
  endtask

  int b_fwd, b_last, b_tsv, tot, m;

  initial begin
    tick();
    chk_en = 1'b1;

    // Default thresholds: nothing is ever forwarded
    do_reset();
    tot = 0;
    for (int c = 0; c < CH; c++) tot += n_fwd[c];
    b_fwd = tot;
    for (int i = 0; i < 1000; i++) begin
      for (int k = 0; k < DATA_W / 32; k++) adc_data[k*32 +: 32] = $urandom;
      adc_valid = '1;
      tick();
    end
    adc_valid = '0;
    tick(); tick(); tick();
    tot = 0;
    for (int c = 0; c < CH; c++) tot += n_fwd[c];
    check("default no fwd", tot - b_fwd, 128'd0);

    // Basic segment on ch0: 0, trigger (sample3=1001), 500, 500, 50
    do_reset();
    cfg_all(1000, 100); cfg_valid = 1'b1; tick();              // ts 0
    cfg_valid = 1'b0;
    b_fwd = n_fwd[0]; b_last = n_last[0]; b_tsv = n_tsv[0];
    adc_valid = 8'h01;
    word(0, 0); tick();                                         // ts 1
    word(0, 0); adc_data[(0*PS+3)*SW +: SW] = 16'd1001; tick(); // ts 2
    word(0, 500); tick(); tick();                               // ts 3,4
    word(0, 50); tick();                                        // ts 5
    adc_valid = '0; tick(); tick(); tick();
    check("basic fwd", n_fwd[0] - b_fwd, 128'd4);
    check("basic last", n_last[0] - b_last, 128'd1);
    check("basic tsv", n_tsv[0] - b_tsv, 128'd1);
    check("basic ts", cap_ts[0], 128'd2);
    check("basic ts_w", cap_tsw[0], 128'd2);

    // Boundaries: equal to high does not trigger, containing low does not exit
    b_fwd = n_fwd[0]; b_last = n_last[0];
    adc_valid = 8'h01;
    word(0, 1000); tick();
    word(0, 1001); tick();
    word(0, 100); tick();
    word(0, 99); adc_data[(0*PS+5)*SW +: SW] = 16'd100; tick();
    word(0, 99); tick();
    adc_valid = '0; tick(); tick(); tick();
    check("bound fwd", n_fwd[0] - b_fwd, 128'd4);
    check("bound last", n_last[0] - b_last, 128'd1);

    // Gaps and independence: ch0 and ch3 with different thresholds
    cfg_all(1000, 100);
    cfg_thresh_high[3*SW +: SW] = SW'(-50);
    cfg_thresh_low[3*SW +: SW]  = SW'(-300);
    cfg_valid = 1'b1; tick(); cfg_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      adc_valid = '0;
      adc_valid[0] = 1'($urandom_range(1));
      adc_valid[3] = 1'($urandom_range(1));
      m = int'($urandom_range(2));
      case (m)
        0:       rand_word(0, 0, 99);
        1:       rand_word(0, 100, 1000);
        default: rand_word(0, -200, 1200);
      endcase
      m = int'($urandom_range(2));
      case (m)
        0:       rand_word(3, -400, -301);
        1:       rand_word(3, -300, -50);
        default: rand_word(3, -400, 50);
      endcase
      tick();
    end
    adc_valid = '0; tick(); tick(); tick();

    // Reset in mid-segment: no out_last, new segment timestamped post-reset
    do_reset();
    cfg_all(1000, 100); cfg_valid = 1'b1; tick(); cfg_valid = 1'b0; // ts 0
    b_fwd = n_fwd[0]; b_last = n_last[0]; b_tsv = n_tsv[0];
    adc_valid = 8'h01;
    word(0, 2000); tick();                                      // ts 1 trigger
    word(0, 500); tick();                                       // ts 2
    reset = 1'b1; tick(); reset = 1'b0;                         // word discarded
    adc_valid = '0; cfg_valid = 1'b1; tick(); cfg_valid = 1'b0; // ts 0
    tick();                                                     // ts 1
    adc_valid = 8'h01; word(0, 2000); tick();                   // ts 2 trigger
    adc_valid = '0; tick(); tick(); tick();
    check("rst fwd", n_fwd[0] - b_fwd, 128'd2);
    check("rst last", n_last[0] - b_last, 128'd0);
    check("rst tsv", n_tsv[0] - b_tsv, 128'd2);
    check("rst ts", cap_ts[0], 128'd2);

    // Config in mid-segment: low = 2000 makes the following word exit
    b_last = n_last[0];
    cfg_all(1000, 2000); cfg_valid = 1'b1;
    adc_valid = 8'h01; word(0, 500); tick();
    cfg_valid = 1'b0; word(0, 1500); tick();
    adc_valid = '0; tick(); tick(); tick();
    check("cfg exit last", n_last[0] - b_last, 128'd1);

    // Timestamp wrap on the 4-bit instance
    do_reset();
    cfg_all(1000, 100); cfg_valid = 1'b1; tick(); cfg_valid = 1'b0; // ts 0
    for (int i = 0; i < 14; i++) tick();                        // ts 1..14
    adc_valid = 8'h01; word(0, 1001); tick();                   // ts 15
    adc_valid = '0; tick();                                     // ts 16
    adc_valid = 8'h02; word(1, 1001); tick();                   // ts 17
    adc_valid = '0; tick(); tick(); tick();
    check("wrap ts_w ch0", cap_tsw[0], 128'd15);
    check("wrap ts_w ch1", cap_tsw[1], 128'd1);
    check("wrap ts ch1", cap_ts[1], 128'd17);

    // low > high: a single word opens and closes a segment
    cfg_all(100, 500); cfg_valid = 1'b1; tick(); cfg_valid = 1'b0;
    b_last = n_last[2]; b_tsv = n_tsv[2];
    adc_valid = 8'h04; word(2, 200); tick(); tick();
    adc_valid = '0; tick(); tick(); tick();
    check("single tsv", n_tsv[2] - b_tsv, 128'd2);
    check("single last", n_last[2] - b_last, 128'd2);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
